ram_arbiter_2client: RTL and testbench

Two-client access controller for a single-port RAM with synchronous write and asynchronous read. After reset it clears the whole RAM with one write per cycle. It then shares the single RAM port between clients A and B, granting at most one access per cycle and returning read data one cycle after the grant. It sits between two datapath masters and one single-port RAM instance.

---
 rtl/ram_arbiter_2client_if.sv | 50 +++++
 rtl/ram_arbiter_2client.sv | 132 +++++++++++++
 tb/tb_ram_arbiter_2client.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_2client_if.sv
// Bus bundle for ram_arbiter_2client: client A/B handshakes, the RAM port and
// the init_done status. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding clients and RAM.
interface ram_arbiter_2client_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  init_done;

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_dout;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_din;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_dout;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    output init_done,
    input  a_req, a_we, a_addr, a_din,
    output a_gnt, a_rvalid, a_dout,
    input  b_req, b_we, b_addr, b_din,
    output b_gnt, b_rvalid, b_dout,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    input  init_done,
    output a_req, a_we, a_addr, a_din,
    input  a_gnt, a_rvalid, a_dout,
    output b_req, b_we, b_addr, b_din,
    input  b_gnt, b_rvalid, b_dout,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_arbiter_2client.sv
// Two-client arbiter for a single-port RAM (sync write, async read).
// After reset it clears every RAM word with one write per cycle, then grants
// at most one client access per cycle. Read data is registered one cycle
// after the grant.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie break (client not served
// most recently wins). Undefined: fixed priority, A wins every tie.
module ram_arbiter_2client #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram_arbiter_2client_if.slave  bus
);

  typedef enum logic {INIT, SERVE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_done;
  logic                  a_gnt, b_gnt;
  logic                  a_rvalid, b_rvalid;
  logic [DATA_WIDTH-1:0] a_dout, b_dout;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;  // 1: B was granted most recently

  // Last-served pointer, reset to B so A wins the first tie
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_b <= 1'b1;
    end else if (a_gnt) begin
      last_b <= 1'b0;
    end else if (b_gnt) begin
      last_b <= 1'b1;
    end
  end
`endif

  // Next state, grant selection and RAM port mux
  always_comb begin
    state_next = state;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    case (state)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = init_addr;
        if (init_addr == '1) begin
          state_next = SERVE;
        end
      end
      SERVE: begin
        if (bus.a_req && bus.b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          a_gnt = last_b;
          b_gnt = !last_b;
`else
          a_gnt = 1'b1;
`endif
        end else begin
          a_gnt = bus.a_req;
          b_gnt = bus.b_req;
        end
        if (a_gnt) begin
          ram_we   = bus.a_we;
          ram_addr = bus.a_addr;
          ram_din  = bus.a_din;
        end else if (b_gnt) begin
          ram_we   = bus.b_we;
          ram_addr = bus.b_addr;
          ram_din  = bus.b_din;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // State register, clear-sweep address and init_done flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= INIT;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        init_addr <= init_addr + 1'b1;
        if (init_addr == '1) begin
          init_done <= 1'b1;
        end
      end
    end
  end

  // Capture read data at the end of a read grant; writes leave dout alone
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
    end else begin
      a_rvalid <= a_gnt && !bus.a_we;
      b_rvalid <= b_gnt && !bus.b_we;
      if (a_gnt && !bus.a_we) begin
        a_dout <= bus.ram_dout;
      end
      if (b_gnt && !bus.b_we) begin
        b_dout <= bus.ram_dout;
      end
    end
  end

  assign bus.init_done = init_done;
  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.a_rvalid  = a_rvalid;
  assign bus.b_rvalid  = b_rvalid;
  assign bus.a_dout    = a_dout;
  assign bus.b_dout    = b_dout;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;

endmodule

// File: tb/tb_ram_arbiter_2client.sv
// Testbench for ram_arbiter_2client with ADDR_WIDTH=4, DATA_WIDTH=8.
// Directed stimulus; expected read data goes into per-client queues that a
// separate monitor drains whenever a_rvalid/b_rvalid is seen.
module tb_ram_arbiter_2client;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic fill;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];

  ram_arbiter_2client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter_2client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, asynchronous read, optional 0xFF pre-fill
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'hFF;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
  end
  assign bus.ram_dout = mem[bus.ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_din = '0;
  endtask

  // Monitor: every rvalid pulse must match the next queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (bus.a_rvalid) begin
        if (a_q.size() == 0) check("a_rvalid_unexpected", 1, 0);
        else check("a_dout", bus.a_dout, a_q.pop_front());
      end
      if (bus.b_rvalid) begin
        if (b_q.size() == 0) check("b_rvalid_unexpected", 1, 0);
        else check("b_dout", bus.b_dout, b_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_a [4];
    reset_n = 1'b0;
    fill    = 1'b1;
    idle_inputs();
`ifdef ARB_ROUND_ROBIN_EN
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    cyc();
    cyc();
    fill = 1'b0;
    #1;
    check("rst_init_done", bus.init_done, 0);
    check("rst_a_rvalid", bus.a_rvalid, 0);
    check("rst_b_rvalid", bus.b_rvalid, 0);
    check("rst_a_dout", bus.a_dout, 0);
    check("rst_b_dout", bus.b_dout, 0);
    check("rst_ram_we", bus.ram_we, 1);
    check("rst_ram_addr", bus.ram_addr, 0);

    // Release reset with A already requesting a read of address 5
    @(negedge clk);
    reset_n = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd5;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("sweep_ram_we", bus.ram_we, 1);
      check("sweep_ram_addr", bus.ram_addr, k);
      check("sweep_ram_din", bus.ram_din, 0);
      check("sweep_a_gnt", bus.a_gnt, 0);
      check("sweep_init_done", bus.init_done, 0);
      cyc();
    end
    #1;
    check("init_done_set", bus.init_done, 1);
    check("serve0_a_gnt", bus.a_gnt, 1);
    check("serve0_ram_addr", bus.ram_addr, 5);
    check("serve0_ram_we", bus.ram_we, 0);
    a_q.push_back(8'h00);
    cyc();

    // B reads address 7 (cleared by the sweep)
    idle_inputs();
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd7;
    #1;
    check("b_rd7_b_gnt", bus.b_gnt, 1);
    check("b_rd7_a_gnt", bus.a_gnt, 0);
    b_q.push_back(8'h00);
    cyc();

    // A writes 0x5A to address 3
    idle_inputs();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd3; bus.a_din = 8'h5A;
    #1;
    check("a_wr_a_gnt", bus.a_gnt, 1);
    check("a_wr_b_gnt", bus.b_gnt, 0);
    check("a_wr_ram_we", bus.ram_we, 1);
    check("a_wr_ram_addr", bus.ram_addr, 3);
    check("a_wr_ram_din", bus.ram_din, 8'h5A);
    cyc();

    // A reads address 3 back; write must not have touched a_dout/a_rvalid
    check("after_wr_a_rvalid", bus.a_rvalid, 0);
    check("after_wr_a_dout", bus.a_dout, 8'h00);
    bus.a_we = 1'b0; bus.a_din = '0;
    #1;
    check("a_rd3_a_gnt", bus.a_gnt, 1);
    check("a_rd3_b_gnt", bus.b_gnt, 0);
    a_q.push_back(8'h5A);
    cyc();

    // Idle cycle: RAM port parked at zero
    idle_inputs();
    #1;
    check("idle_ram_we", bus.ram_we, 0);
    check("idle_ram_addr", bus.ram_addr, 0);
    check("idle_ram_din", bus.ram_din, 0);
    check("idle_a_gnt", bus.a_gnt, 0);
    check("idle_b_gnt", bus.b_gnt, 0);
    cyc();

    // B writes 0x33 to address 9
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'd9; bus.b_din = 8'h33;
    #1;
    check("b_wr_b_gnt", bus.b_gnt, 1);
    check("b_wr_ram_din", bus.ram_din, 8'h33);
    cyc();

    // Four cycles with both clients reading: A addr 3, B addr 9
    idle_inputs();
    bus.a_req = 1'b1; bus.a_addr = 4'd3;
    bus.b_req = 1'b1; bus.b_addr = 4'd9;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_a_gnt", bus.a_gnt, exp_a[k]);
      check("tie_b_gnt", bus.b_gnt, !exp_a[k]);
      if (exp_a[k]) a_q.push_back(8'h5A);
      else          b_q.push_back(8'h33);
      cyc();
    end

    // Reset asserted during a B read grant: no rvalid, sweep restarts
    idle_inputs();
    cyc();
    bus.b_req = 1'b1; bus.b_addr = 4'd9;
    reset_n = 1'b0;
    #1;
    check("rst_serve_b_gnt", bus.b_gnt, 1);
    cyc();
    reset_n = 1'b1;
    idle_inputs();
    #1;
    check("rst2_b_rvalid", bus.b_rvalid, 0);
    check("rst2_init_done", bus.init_done, 0);
    check("rst2_b_dout", bus.b_dout, 0);
    check("rst2_ram_we", bus.ram_we, 1);
    check("rst2_ram_addr", bus.ram_addr, 0);
    cyc();
    #1;
    check("rst2_ram_addr1", bus.ram_addr, 1);
    check("rst2_b_rvalid_late", bus.b_rvalid, 0);
    cyc();
    cyc();

    check("a_q_drained", a_q.size(), 0);
    check("b_q_drained", b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
